// File: rtl/ripple_count_monitor.sv
// Monitors a free-running 4-bit ripple counter from another clock domain.
// Filters and synchronizes the count, extends it with a wrap counter, flags anomalies, and serves snapshots.
module ripple_count_monitor (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  q_in,
  input  logic        clr,
  input  logic        rd_req,
  output logic [3:0]  cnt_q,
  output logic [11:0] ext_count,
  output logic        rd_valid,
  output logic [11:0] snap,
  output logic        ovf,
  output logic        skip_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    HOLD = 2'd2
  } state_t;

  logic [3:0]  r_s1;
  logic [3:0]  r_s2;
  logic [3:0]  r_s3;
  logic [1:0]  r_fill;
  logic [3:0]  r_cnt;
  logic [7:0]  r_wrap;
  logic        r_primed;
  logic        r_ovf;
  logic        r_skip;
  logic [11:0] r_snap;
  logic        r_rd_valid;
  state_t      r_state;

  logic        w_accept;
  logic        w_moved;
  logic        w_wrap;
  logic        w_skip;
  logic [3:0]  w_next;
  logic [11:0] w_ext;

  // Until the pipeline holds real samples, the reset zeros in s2/s3 must not be taken as a count.
  assign w_accept = (r_s2 == r_s3) && (r_primed || (r_fill == 2'd3));
  assign w_next   = r_cnt + 4'd1;
  assign w_moved  = w_accept && r_primed && (r_s2 != r_cnt);
  assign w_wrap   = w_moved && (r_s2 < r_cnt);
  assign w_skip   = w_moved && (r_s2 != w_next);
  assign w_ext    = {r_wrap, r_cnt};

  // Synchronizer plus stability-compare stage, and pipeline fill tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1   <= 4'd0;
      r_s2   <= 4'd0;
      r_s3   <= 4'd0;
      r_fill <= 2'd0;
    end else begin
      r_s1 <= q_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (r_fill != 2'd3) begin
        r_fill <= r_fill + 2'd1;
      end else begin
        r_fill <= r_fill;
      end
    end
  end

  // Filtered count register and primed flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= 4'd0;
      r_primed <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= r_s2;
      r_primed <= 1'b1;
    end else begin
      r_cnt    <= r_cnt;
      r_primed <= r_primed;
    end
  end

  // Wrap counter and sticky error flags; clr wins over a same-edge event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrap <= 8'd0;
      r_ovf  <= 1'b0;
      r_skip <= 1'b0;
    end else if (clr) begin
      r_wrap <= 8'd0;
      r_ovf  <= 1'b0;
      r_skip <= 1'b0;
    end else begin
      if (w_wrap) begin
        if (r_wrap == 8'hFF) begin
          r_ovf <= 1'b1;
        end else begin
          r_wrap <= r_wrap + 8'd1;
        end
      end
      if (w_skip) begin
        r_skip <= 1'b1;
      end
    end
  end

  // Snapshot handshake FSM with registered rd_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_snap     <= 12'd0;
      r_rd_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rd_valid <= 1'b0;
          if (rd_req) begin
            r_state <= CAPT;
          end
        end
        CAPT: begin
          r_snap     <= w_ext;
          r_rd_valid <= 1'b1;
          r_state    <= HOLD;
        end
        HOLD: begin
          if (!rd_req) begin
            r_rd_valid <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_rd_valid <= 1'b1;
          end
        end
        default: begin
          r_rd_valid <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign cnt_q     = r_cnt;
  assign ext_count = w_ext;
  assign rd_valid  = r_rd_valid;
  assign snap      = r_snap;
  assign ovf       = r_ovf;
  assign skip_err  = r_skip;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Scoreboard bench for ripple_count_monitor: a spec-level model predicts the count state per stable input value.
module tb_ripple_count_monitor;

  logic        clk;
  logic        reset;
  logic [3:0]  q_in;
  logic        clr;
  logic        rd_req;
  logic [3:0]  cnt_q;
  logic [11:0] ext_count;
  logic        rd_valid;
  logic [11:0] snap;
  logic        ovf;
  logic        skip_err;

  ripple_count_monitor dut (
    .clk(clk), .reset(reset), .q_in(q_in), .clr(clr), .rd_req(rd_req),
    .cnt_q(cnt_q), .ext_count(ext_count), .rd_valid(rd_valid), .snap(snap),
    .ovf(ovf), .skip_err(skip_err)
  );

  typedef struct packed {
    logic [11:0] ext;
    logic        skip;
    logic        ovf;
  } exp_t;

  exp_t        sb_q[$];
  logic [11:0] snap_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [3:0]  m_cnt;
  logic [7:0]  m_wrap;
  logic        m_skip;
  logic        m_ovf;
  logic        m_primed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_cnt = 4'd0; m_wrap = 8'd0; m_skip = 1'b0; m_ovf = 1'b0; m_primed = 1'b0;
  endtask

  task automatic model_accept(input logic [3:0] w);
    logic [3:0] nxt;
    nxt = m_cnt + 4'd1;
    if (!m_primed) begin
      m_cnt = w;
      m_primed = 1'b1;
    end else if (w != m_cnt) begin
      if (w < m_cnt) begin
        if (m_wrap == 8'd255) m_ovf = 1'b1;
        else m_wrap = m_wrap + 8'd1;
      end
      if (w != nxt) m_skip = 1'b1;
      m_cnt = w;
    end
  endtask

  // Drive one stable value, record its predicted outcome, and hold it.
  task automatic step(input logic [3:0] v, input int hold);
    exp_t e;
    q_in = v;
    model_accept(v);
    e = {m_wrap, m_cnt, m_skip, m_ovf};
    sb_q.push_back(e);
    repeat (hold) tick;
  endtask

  task automatic apply_reset(input logic [3:0] v);
    reset = 1'b0; q_in = v; rd_req = 1'b0; clr = 1'b0;
    sb_q.delete(); snap_q.delete();
    tick; tick;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset;
    exp_t e;
    reset = 1'b0; q_in = 4'd5; rd_req = 1'b0; clr = 1'b0;
    model_reset();
    tick; tick;
    n_cmp++;
    if ({cnt_q, ext_count, snap, rd_valid, ovf, skip_err} !== 31'd0) begin
      n_bad++;
      $display("FAIL reset_state: got cnt=%h ext=%h snap=%h v=%b ovf=%b skip=%b, want all 0",
               cnt_q, ext_count, snap, rd_valid, ovf, skip_err);
    end
    reset = 1'b1;
    model_accept(4'd5);
    e = {m_wrap, m_cnt, m_skip, m_ovf};
    sb_q.push_back(e);
    repeat (3) tick;
    n_cmp++;
    if (cnt_q !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_latency_early: cnt_q=%h at 3rd edge, want 0", cnt_q);
    end
    tick;
    e = sb_q.pop_front();
    n_cmp++;
    if ({ext_count, skip_err, ovf} !== {e.ext, e.skip, e.ovf}) begin
      n_bad++;
      $display("FAIL reset_first_value: ext=%h skip=%b ovf=%b, want ext=%h skip=%b ovf=%b",
               ext_count, skip_err, ovf, e.ext, e.skip, e.ovf);
    end
  endtask

  task automatic test_count_seq;
    exp_t e;
    apply_reset(4'd0);
    for (int i = 0; i < 20; i++) begin
      step(4'(i % 16), 8);
      e = sb_q.pop_front();
      n_cmp++;
      if ({ext_count, skip_err, ovf} !== {e.ext, e.skip, e.ovf}) begin
        n_bad++;
        $display("FAIL count_seq[%0d]: ext=%h skip=%b ovf=%b, want ext=%h skip=%b ovf=%b",
                 i, ext_count, skip_err, ovf, e.ext, e.skip, e.ovf);
      end
    end
    n_cmp++;
    if ({ext_count, skip_err} !== {12'h013, 1'b0}) begin
      n_bad++;
      $display("FAIL count_seq_final: ext=%h skip=%b, want ext=013 skip=0", ext_count, skip_err);
    end
  endtask

  task automatic test_skip;
    exp_t e;
    apply_reset(4'd0);
    step(4'd4, 8);
    step(4'd7, 8);
    for (int i = 0; i < 2; i++) begin
      e = sb_q.pop_front();
      if (i == 1) begin
        n_cmp++;
        if ({ext_count, skip_err, ovf} !== {e.ext, e.skip, e.ovf}) begin
          n_bad++;
          $display("FAIL skip_detect: ext=%h skip=%b ovf=%b, want ext=%h skip=%b ovf=%b",
                   ext_count, skip_err, ovf, e.ext, e.skip, e.ovf);
        end
      end
    end
    clr = 1'b1;
    tick;
    clr = 1'b0;
    m_wrap = 8'd0; m_skip = 1'b0; m_ovf = 1'b0;
    e = {m_wrap, m_cnt, m_skip, m_ovf};
    sb_q.push_back(e);
    tick;
    e = sb_q.pop_front();
    n_cmp++;
    if ({ext_count, skip_err, ovf} !== {e.ext, e.skip, e.ovf}) begin
      n_bad++;
      $display("FAIL skip_clr: ext=%h skip=%b ovf=%b, want ext=%h skip=%b ovf=%b",
               ext_count, skip_err, ovf, e.ext, e.skip, e.ovf);
    end
  endtask

  task automatic test_wrap_sat;
    exp_t e;
    apply_reset(4'd0);
    step(4'd0, 4);
    void'(sb_q.pop_front());
    for (int w = 0; w < 256; w++) begin
      for (int v = 1; v <= 16; v++) begin
        step(4'(v % 16), 4);
        e = sb_q.pop_front();
        n_cmp++;
        if ({ext_count, skip_err, ovf} !== {e.ext, e.skip, e.ovf}) begin
          n_bad++;
          $display("FAIL wrap_sat[%0d.%0d]: ext=%h skip=%b ovf=%b, want ext=%h skip=%b ovf=%b",
                   w, v, ext_count, skip_err, ovf, e.ext, e.skip, e.ovf);
        end
      end
    end
    n_cmp++;
    if ({ext_count[11:4], ovf} !== {8'hFF, 1'b1}) begin
      n_bad++;
      $display("FAIL wrap_saturated: wrap=%h ovf=%b, want wrap=ff ovf=1", ext_count[11:4], ovf);
    end
    for (int v = 1; v <= 15; v++) begin
      step(4'(v), 4);
      void'(sb_q.pop_front());
    end
    // Time clr onto the very edge where the 15->0 wrap is accepted.
    q_in = 4'd0;
    m_cnt = 4'd0; m_wrap = 8'd0; m_skip = 1'b0; m_ovf = 1'b0;
    e = {m_wrap, m_cnt, m_skip, m_ovf};
    sb_q.push_back(e);
    repeat (3) tick;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    e = sb_q.pop_front();
    n_cmp++;
    if ({ext_count, skip_err, ovf} !== {e.ext, e.skip, e.ovf}) begin
      n_bad++;
      $display("FAIL wrap_vs_clr: ext=%h skip=%b ovf=%b, want ext=%h skip=%b ovf=%b",
               ext_count, skip_err, ovf, e.ext, e.skip, e.ovf);
    end
  endtask

  task automatic test_snapshot;
    int cyc;
    logic [11:0] want;
    apply_reset(4'd0);
    step(4'd0, 4);
    for (int w = 0; w < 42; w++) begin
      for (int v = 1; v <= 16; v++) step(4'(v % 16), 4);
    end
    for (int v = 1; v <= 9; v++) step(4'(v), 4);
    sb_q.delete();
    n_cmp++;
    if (ext_count !== 12'h2A9) begin
      n_bad++;
      $display("FAIL snap_setup: ext=%h, want 2a9", ext_count);
    end
    rd_req = 1'b1;
    q_in = 4'd10;
    snap_q.push_back({m_wrap, m_cnt});
    model_accept(4'd10);
    cyc = 0;
    while (!rd_valid && cyc < 10) begin
      tick;
      cyc++;
    end
    n_cmp++;
    if (cyc !== 2) begin
      n_bad++;
      $display("FAIL snap_latency: rd_valid after %0d edges, want 2", cyc);
    end
    want = snap_q.pop_front();
    n_cmp++;
    if (snap !== want) begin
      n_bad++;
      $display("FAIL snap_value: snap=%h, want %h", snap, want);
    end
    repeat (6) tick;
    n_cmp++;
    if ({ext_count, snap, rd_valid} !== {m_wrap, m_cnt, want, 1'b1}) begin
      n_bad++;
      $display("FAIL snap_hold: ext=%h snap=%h v=%b, want ext=%h snap=%h v=1",
               ext_count, snap, rd_valid, {m_wrap, m_cnt}, want);
    end
    rd_req = 1'b0;
    tick;
    n_cmp++;
    if ({rd_valid, snap} !== {1'b0, want}) begin
      n_bad++;
      $display("FAIL snap_release: v=%b snap=%h, want v=0 snap=%h", rd_valid, snap, want);
    end
    rd_req = 1'b1;
    snap_q.push_back({m_wrap, m_cnt});
    tick;
    rd_req = 1'b0;
    tick;
    want = snap_q.pop_front();
    n_cmp++;
    if ({rd_valid, snap} !== {1'b1, want}) begin
      n_bad++;
      $display("FAIL capt_drop_hold: v=%b snap=%h, want v=1 snap=%h", rd_valid, snap, want);
    end
    tick;
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL capt_drop_idle: v=%b, want 0", rd_valid);
    end
  endtask

  task automatic test_glitch_and_abort;
    exp_t e;
    int cyc;
    apply_reset(4'd3);
    step(4'd3, 8);
    void'(sb_q.pop_front());
    e = {m_wrap, m_cnt, m_skip, m_ovf};
    sb_q.push_back(e);
    q_in = 4'hB;
    tick;
    q_in = 4'd3;
    repeat (8) tick;
    e = sb_q.pop_front();
    n_cmp++;
    if ({ext_count, skip_err, ovf} !== {e.ext, e.skip, e.ovf}) begin
      n_bad++;
      $display("FAIL glitch_filter: ext=%h skip=%b ovf=%b, want ext=%h skip=%b ovf=%b",
               ext_count, skip_err, ovf, e.ext, e.skip, e.ovf);
    end
    rd_req = 1'b1;
    snap_q.push_back({m_wrap, m_cnt});
    tick; tick;
    n_cmp++;
    if ({rd_valid, snap} !== {1'b1, snap_q.pop_front()}) begin
      n_bad++;
      $display("FAIL abort_pre_hold: v=%b snap=%h, want v=1 snap=%h", rd_valid, snap, {m_wrap, m_cnt});
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({rd_valid, snap, cnt_q} !== 17'd0) begin
      n_bad++;
      $display("FAIL abort_async: v=%b snap=%h cnt=%h, want all 0", rd_valid, snap, cnt_q);
    end
    tick;
    reset = 1'b1;
    model_reset();
    cyc = 0;
    while (!rd_valid && cyc < 10) begin
      tick;
      cyc++;
    end
    n_cmp++;
    if (cyc !== 2) begin
      n_bad++;
      $display("FAIL abort_recapture: rd_valid after %0d edges, want 2", cyc);
    end
    rd_req = 1'b0;
    tick;
  endtask

  initial begin
    reset = 1'b0; q_in = 4'd0; clr = 1'b0; rd_req = 1'b0;
    model_reset();
    test_reset();
    test_count_seq();
    test_skip();
    test_wrap_sat();
    test_snapshot();
    test_glitch_and_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
